// File: rtl/wls_pkg.sv
// Shared types and default dimensions for the weight-load sequencer.
package wls_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    WRITE,
    DONE
  } wls_state_e;

  localparam int WLS_DEF_ROWS    = 3;
  localparam int WLS_DEF_COLS    = 3;
  localparam int WLS_DEF_DATA_W  = 8;
  localparam int WLS_DEF_ADDR_W  = 8;
  localparam int WLS_DEF_TIMEOUT = 16;

endpackage

// File: rtl/weight_index_counter.sv
// Row/column index pair for the weight array: column runs fastest, both wrap
// to zero after the last weight; 'last' flags the final (row, col) position.
module weight_index_counter
  import wls_pkg::*;
#(
  parameter int WEIGHT_ROWS = WLS_DEF_ROWS,
  parameter int WEIGHT_COLS = WLS_DEF_COLS,
  localparam int ROW_W = $clog2(WEIGHT_ROWS),
  localparam int COL_W = $clog2(WEIGHT_COLS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             inc,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             last
);

  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(WEIGHT_ROWS - 1);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(WEIGHT_COLS - 1);

  assign last = (row == ROW_MAX) && (col == COL_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row <= '0;
      col <= '0;
    end else if (clear) begin
      row <= '0;
      col <= '0;
    end else if (inc) begin
      if (col == COL_MAX) begin
        col <= '0;
        row <= (row == ROW_MAX) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/weight_load_sequencer.sv
// Fetches WEIGHT_ROWS x WEIGHT_COLS weights from memory and writes them into the
// systolic array one per WRITE cycle. Optional abort on a stalled read: WLS_TIMEOUT_EN.
module weight_load_sequencer
  import wls_pkg::*;
#(
  parameter int WEIGHT_ROWS = WLS_DEF_ROWS,
  parameter int WEIGHT_COLS = WLS_DEF_COLS,
  parameter int DATA_WIDTH  = WLS_DEF_DATA_W,
  parameter int ADDR_WIDTH  = WLS_DEF_ADDR_W,
  parameter int TIMEOUT_CYC = WLS_DEF_TIMEOUT,
  localparam int ROW_W = $clog2(WEIGHT_ROWS),
  localparam int COL_W = $clog2(WEIGHT_COLS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ready,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  weight_enable,
  output logic [ROW_W-1:0]      weight_row,
  output logic [COL_W-1:0]      weight_col,
  output logic [DATA_WIDTH-1:0] weight_data,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_err
);

  wls_state_e            state, state_nx;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] offset_q;
  logic [DATA_WIDTH-1:0] data_p0;
  logic                  idx_last;
  logic                  timeout_hit;
  logic                  abort;

  always_comb begin
    state_nx = state;
    abort    = 1'b0;
    case (state)
      IDLE:  if (start) state_nx = REQ;
      REQ:   if (mem_ready) state_nx = WAIT;
      WAIT: begin
        if (mem_rvalid) begin
          state_nx = WRITE;
        end else if (timeout_hit) begin
          state_nx = IDLE;
          abort    = 1'b1;
        end
      end
      WRITE: state_nx = idx_last ? DONE : REQ;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Address generation: base latched on an accepted start, offset tracks the weight index.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_q   <= '0;
      offset_q <= '0;
    end else begin
      if (state == IDLE && start) base_q <= base_addr;
      if (abort || (state == WRITE && idx_last)) begin
        offset_q <= '0;
      end else if (state == WRITE) begin
        offset_q <= offset_q + 1'b1;
      end
    end
  end

  // Stage p0: read data captured in WAIT, presented to the array during WRITE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_p0 <= '0;
    end else if (state == WAIT && mem_rvalid) begin
      data_p0 <= mem_rdata;
    end
  end

  weight_index_counter #(
    .WEIGHT_ROWS (WEIGHT_ROWS),
    .WEIGHT_COLS (WEIGHT_COLS)
  ) u_index (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (abort),
    .inc     (state == WRITE),
    .row     (weight_row),
    .col     (weight_col),
    .last    (idx_last)
  );

`ifdef WLS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_q;

  assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign timeout_err = timeout_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= abort;
      if (state == WAIT && !mem_rvalid && !timeout_hit) begin
        wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT_CYC;
  assign timeout_hit    = 1'b0;
  assign timeout_err    = 1'b0;
`endif

  assign mem_req       = (state == REQ);
  assign mem_addr      = base_q + offset_q;
  assign weight_enable = (state == WRITE);
  assign weight_data   = data_p0;
  assign busy          = (state != IDLE);
  assign done          = (state == DONE);

endmodule

// File: tb/tb_weight_load_sequencer.sv
// Directed bench for weight_load_sequencer (3x3, 8-bit): memory responder with
// one-cycle read latency, request logging, and immediate-assertion checks.
module tb_weight_load_sequencer;

  localparam int R = 3;
  localparam int C = 3;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [7:0] base_addr;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ready;
  logic       mem_rvalid;
  logic [7:0] mem_rdata;
  logic       weight_enable;
  logic [1:0] weight_row;
  logic [1:0] weight_col;
  logic [7:0] weight_data;
  logic       busy;
  logic       done;
  logic       timeout_err;

  int n_assert = 0;
  int n_fail   = 0;

  int addr_log[$];
  int wr_row[$];
  int wr_col[$];
  int wr_data[$];
  int cyc        = 0;
  int start_cyc  = 0;
  int done_cnt   = 0;
  int done_cyc   = -1;
  int te_cnt     = 0;
  int te_cyc     = -1;
  int stall_idx  = -1;
  int stall_left = 0;
  int stall_seen = 0;
  logic [7:0] stall_exp = 8'h00;
  bit   prev_acc    = 1'b0;
  logic [7:0] prev_addr = 8'h00;
  bit   hold_rvalid = 1'b0;

  always #5 clk = ~clk;

  weight_load_sequencer dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .base_addr     (base_addr),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ready     (mem_ready),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .weight_enable (weight_enable),
    .weight_row    (weight_row),
    .weight_col    (weight_col),
    .weight_data   (weight_data),
    .busy          (busy),
    .done          (done),
    .timeout_err   (timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive memory response, log DUT activity, decide mem_ready.
  task automatic tick();
    @(negedge clk);
    cyc++;
    start      = 1'b0;
    mem_rvalid = prev_acc && !hold_rvalid;
    mem_rdata  = prev_acc ? (prev_addr ^ 8'h5A) : 8'h00;
    if (weight_enable) begin
      wr_row.push_back(int'(weight_row));
      wr_col.push_back(int'(weight_col));
      wr_data.push_back(int'(weight_data));
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (timeout_err) begin
      te_cnt++;
      te_cyc = cyc;
    end
    mem_ready = 1'b1;
    if (mem_req && addr_log.size() == stall_idx && stall_left > 0) begin
      mem_ready = 1'b0;
      stall_left--;
      stall_seen++;
      chk("stall_addr", 32'(mem_addr), 32'(stall_exp));
    end
    prev_acc  = mem_req && mem_ready;
    prev_addr = mem_addr;
    if (prev_acc) addr_log.push_back(int'(mem_addr));
  endtask

  task automatic begin_load(input logic [7:0] b);
    addr_log.delete();
    wr_row.delete();
    wr_col.delete();
    wr_data.delete();
    done_cnt  = 0;
    done_cyc  = -1;
    base_addr = b;
    start     = 1'b1;
    start_cyc = cyc;
  endtask

  task automatic run_to_idle(input string tag, input int budget);
    int n = 0;
    do begin
      tick();
      n++;
    end while (busy && n < budget);
    chk(tag, 32'(busy), 32'd0);
  endtask

  task automatic check_load(input string tag, input logic [7:0] b, input int lat);
    logic [7:0] a;
    chk({tag, "_n_addr"}, addr_log.size(), R * C);
    chk({tag, "_n_write"}, wr_row.size(), R * C);
    for (int i = 0; i < R * C; i++) begin
      a = b + 8'(i);
      if (i < addr_log.size()) chk({tag, "_addr"}, addr_log[i], 32'(a));
      if (i < wr_row.size()) begin
        chk({tag, "_row"}, wr_row[i], i / C);
        chk({tag, "_col"}, wr_col[i], i % C);
        chk({tag, "_data"}, wr_data[i], 32'(a ^ 8'h5A));
      end
    end
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_latency"}, done_cyc - start_cyc, lat);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_mem_req"}, 32'(mem_req), 0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
    chk({tag, "_wen"}, 32'(weight_enable), 0);
    chk({tag, "_row"}, 32'(weight_row), 0);
    chk({tag, "_col"}, 32'(weight_col), 0);
    chk({tag, "_data"}, 32'(weight_data), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_terr"}, 32'(timeout_err), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset_n    = 1'b0;
    start      = 1'b0;
    base_addr  = 8'h00;
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 8'h00;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    reset_n = 1'b1;
    tick();

    // Basic 3x3 load from 0x10, zero-wait memory
    begin_load(8'h10);
    run_to_idle("basic_finish", 60);
    check_load("basic", 8'h10, 28);

    // Second request stalled five cycles
    stall_idx  = 1;
    stall_left = 5;
    stall_seen = 0;
    stall_exp  = 8'h11;
    begin_load(8'h10);
    run_to_idle("stall_finish", 60);
    chk("stall_cycles", stall_seen, 5);
    check_load("stall", 8'h10, 33);
    stall_idx = -1;

    // Address wrap from 0xFE
    begin_load(8'hFE);
    run_to_idle("wrap_finish", 60);
    check_load("wrap", 8'hFE, 28);

    // Start with a new base while busy is ignored
    begin_load(8'h20);
    repeat (10) tick();
    start     = 1'b1;
    base_addr = 8'h40;
    run_to_idle("midstart_finish", 60);
    check_load("midstart", 8'h20, 28);
    tick();
    chk("midstart_no_restart", 32'(busy), 0);

    // Reset after the 4th write
    begin_load(8'h50);
    n = 0;
    do begin
      tick();
      n++;
    end while (wr_row.size() < 4 && n < 40);
    chk("rst_reached_4_writes", wr_row.size(), 4);
    reset_n    = 1'b0;
    prev_acc   = 1'b0;
    mem_rvalid = 1'b0;
    #1;
    check_quiet("midreset");
    repeat (3) tick();
    chk("midreset_no_done", done_cnt, 0);
    chk("midreset_no_write", wr_row.size(), 4);
    reset_n = 1'b1;
    tick();
    begin_load(8'h30);
    run_to_idle("reload_finish", 60);
    check_load("reload", 8'h30, 28);

`ifdef WLS_TIMEOUT_EN
    begin_load(8'h00);
    hold_rvalid = 1'b1;
    run_to_idle("timeout_finish", 40);
    hold_rvalid = 1'b0;
    chk("timeout_pulses", te_cnt, 1);
    chk("timeout_latency", te_cyc - start_cyc, 18);
    chk("timeout_no_done", done_cnt, 0);
    chk("timeout_no_write", wr_row.size(), 0);
    tick();
    chk("timeout_pulse_width", 32'(timeout_err), 0);
`else
    chk("timeout_never", te_cnt, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
